// File: rtl/snn_load_if.sv
// -----------------------------------------------------------------------------
// snn_load_if
// Signal bundle between the SNN load/classify sequencer and its neighbours
// (UART RX/TX, 1-bit input-image RAM, SNN core).
//
// master : the sequencer (snn_load_ctrl)
//    in  : rx_rdy, rx_data, snn_done, snn_digit, tx_rdy
//    out : ram_we, ram_addr, ram_wdata, snn_start, tx_start, tx_data, busy, ovr
// slave  : the surrounding blocks; same signals with the opposite directions
// -----------------------------------------------------------------------------
interface snn_load_if #(
   parameter int ADDR_W = 10
) ();
   // UART receive side
   logic              rx_rdy;
   logic [7:0]        rx_data;
   // input-image RAM write port
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wdata;
   // SNN core
   logic              snn_start;
   logic              snn_done;
   logic [3:0]        snn_digit;
   // UART transmit side
   logic              tx_rdy;
   logic              tx_start;
   logic [7:0]        tx_data;
   // status
   logic              busy;
   logic              ovr;

   modport master (
      input  rx_rdy, rx_data, snn_done, snn_digit, tx_rdy,
      output ram_we, ram_addr, ram_wdata, snn_start, tx_start, tx_data, busy, ovr
   );

   modport slave (
      output rx_rdy, rx_data, snn_done, snn_digit, tx_rdy,
      input  ram_we, ram_addr, ram_wdata, snn_start, tx_start, tx_data, busy, ovr
   );
endinterface

// File: rtl/snn_load_ctrl.sv
// -----------------------------------------------------------------------------
// snn_load_ctrl
// Top-level sequencer of the SNN digit classifier. Unpacks received bytes
// LSB-first into the 1-bit input-image RAM (one pixel per cycle), starts the
// SNN core once the image is complete, and hands the ASCII result digit to the
// UART transmitter.
//
// Ports:
//    clk  in  system clock, everything on posedge
//    rst  in  synchronous, active-high reset
//    bus  snn_load_if.master : RX byte in, RAM write port, SNN start/done,
//         TX byte out, busy / sticky overrun status
// -----------------------------------------------------------------------------
module snn_load_ctrl #(
   parameter int NUM_PIXELS = 784,  // multiple of 8
   parameter int ADDR_W     = 10    // 2**ADDR_W >= NUM_PIXELS
) (
   input  logic       clk,
   input  logic       rst,
   snn_load_if.master bus
);

   typedef enum logic [2:0] {
      S_LOAD,
      S_UNPACK,
      S_START,
      S_COMPUTE,
      S_TX
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

   state_e            state_q,   state_d;
   logic [7:0]        shift_q,   shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              ovr_q,     ovr_d;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_LOAD;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         pix_cnt_q <= '0;
         tx_data_q <= '0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         tx_data_q <= tx_data_d;
         ovr_q     <= ovr_d;
      end
   end

   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      pix_cnt_d = pix_cnt_q;
      tx_data_d = tx_data_q;
      // A byte that arrives outside LOAD is dropped and flagged until reset.
      ovr_d     = ovr_q | (bus.rx_rdy && (state_q != S_LOAD));

      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = 1'b0;
      bus.snn_start = 1'b0;
      bus.tx_start  = 1'b0;

      unique case (state_q)
         S_LOAD: begin
            if (bus.rx_rdy) begin
               shift_d   = bus.rx_data;
               bit_cnt_d = '0;
               state_d   = S_UNPACK;
            end
         end

         S_UNPACK: begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = pix_cnt_q;
            bus.ram_wdata = shift_q[0];
            shift_d       = {1'b0, shift_q[7:1]};
            bit_cnt_d     = bit_cnt_q + 3'd1;
            // Hold on the last pixel instead of stepping past the image.
            if (pix_cnt_q != LAST_PIX) begin
               pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            end
            if (bit_cnt_q == 3'd7) begin
               state_d = (pix_cnt_q == LAST_PIX) ? S_START : S_LOAD;
            end
         end

         S_START: begin
            bus.snn_start = 1'b1;
            state_d       = S_COMPUTE;
         end

         S_COMPUTE: begin
            if (bus.snn_done) begin
               tx_data_d = (bus.snn_digit <= 4'd9) ? (8'h30 + {4'h0, bus.snn_digit})
                                                   : 8'h3F;
               state_d   = S_TX;
            end
         end

         S_TX: begin
            if (bus.tx_rdy) begin
               bus.tx_start = 1'b1;
               pix_cnt_d    = '0;
               state_d      = S_LOAD;
            end
         end

         default: state_d = S_LOAD;
      endcase
   end

   assign bus.tx_data = tx_data_q;
   assign bus.busy    = (state_q != S_LOAD);
   assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_snn_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_load_ctrl
// Self-checking bench for snn_load_ctrl. A timeline model predicts, for every
// clock edge, what the outputs must be: each accepted byte owns the eight edges
// after it for its RAM writes, the image-complete start pulse falls nine edges
// after the last byte, and so on. Directed scenarios plus a randomized phase.
// -----------------------------------------------------------------------------
module tb_snn_load_ctrl;

   localparam int NUM_PIXELS = 784;
   localparam int ADDR_W     = 10;
   localparam int NUM_BYTES  = NUM_PIXELS / 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   snn_load_if #(.ADDR_W(ADDR_W)) bus ();

   snn_load_ctrl #(
      .NUM_PIXELS(NUM_PIXELS),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;   // number of posedges seen so far

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc + 1);
      end
   endtask

   // ------------------------------------------------------------------ model
   // Everything is expressed as edge numbers: "edge e" is the posedge that
   // samples the outputs shown during the cycle before it.
   bit         model_on  = 1'b0;
   bit         wr_valid  = 1'b0;
   int         wr_first  = 0;     // first edge of the current byte's writes
   int         wr_base   = 0;     // pixel address of that byte's bit 0
   logic [7:0] wr_byte   = '0;
   int         next_free = 0;     // first edge at which a new byte is accepted
   bit         wait_done = 1'b0;  // image complete, result not yet delivered
   int         done_from = 0;
   bit         wait_tx   = 1'b0;  // result latched, waiting for the UART
   int         tx_from   = 0;
   int         n_bytes   = 0;     // bytes of the current image accepted
   int         start_edge = -1;
   logic [7:0] m_tx_data = '0;
   bit         m_ovr     = 1'b0;
   bit         m_ld;

   function automatic bit loadable(input int e);
      return !wait_done && !wait_tx && (e >= next_free);
   endfunction

   function automatic logic [7:0] ascii_of(input logic [3:0] d);
      int v;
      v = int'(d);
      if (v < 10) return 8'(48 + v);   // '0' + digit
      return 8'd63;                    // '?'
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         model_on   = 1'b1;
         wr_valid   = 1'b0;
         next_free  = 0;
         wait_done  = 1'b0;
         wait_tx    = 1'b0;
         start_edge = -1;
         n_bytes    = 0;
         m_tx_data  = '0;
         m_ovr      = 1'b0;
      end else if (model_on) begin
         m_ld = loadable(cyc);
         if (bus.rx_rdy) begin
            if (m_ld) begin
               wr_valid = 1'b1;
               wr_first = cyc + 1;
               wr_base  = 8 * n_bytes;
               wr_byte  = bus.rx_data;
               n_bytes++;
               if (n_bytes == NUM_BYTES) begin
                  start_edge = cyc + 9;
                  done_from  = cyc + 10;
                  wait_done  = 1'b1;
               end else begin
                  next_free = cyc + 9;
               end
            end else begin
               m_ovr = 1'b1;
            end
         end
         if (wait_done && cyc >= done_from && bus.snn_done) begin
            m_tx_data = ascii_of(bus.snn_digit);
            wait_done = 1'b0;
            wait_tx   = 1'b1;
            tx_from   = cyc + 1;
         end else if (wait_tx && cyc >= tx_from && bus.tx_rdy) begin
            wait_tx   = 1'b0;
            next_free = cyc + 1;
            n_bytes   = 0;
         end
      end
   end

   // ------------------------------------------------- compare + observation
   int   log_addr[$];
   logic log_data[$];
   int   n_starts = 0;
   int   n_txs    = 0;
   int   last_start_edge = -1;
   int   cmp_e;
   bit   in_win;

   always @(negedge clk) begin
      if (model_on) begin
         cmp_e  = cyc + 1;
         in_win = wr_valid && (cmp_e >= wr_first) && (cmp_e < wr_first + 8);
         check("ram_we",    bus.ram_we,    in_win);
         check("ram_addr",  bus.ram_addr,  in_win ? wr_base + (cmp_e - wr_first) : 0);
         check("ram_wdata", bus.ram_wdata, in_win ? wr_byte[cmp_e - wr_first] : 1'b0);
         check("snn_start", bus.snn_start, cmp_e == start_edge);
         check("tx_start",  bus.tx_start,  wait_tx && (cmp_e >= tx_from) && bus.tx_rdy);
         check("tx_data",   bus.tx_data,   m_tx_data);
         check("busy",      bus.busy,      !loadable(cmp_e));
         check("ovr",       bus.ovr,       m_ovr);
      end
      if (bus.ram_we === 1'b1) begin
         log_addr.push_back(int'(bus.ram_addr));
         log_data.push_back(bus.ram_wdata);
      end
      if (bus.snn_start === 1'b1) begin
         n_starts++;
         last_start_edge = cyc + 1;
      end
      if (bus.tx_start === 1'b1) n_txs++;
   end

   // --------------------------------------------------------------- stimulus
   int last_rx_edge = 0;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_rdy  = 1'b1;
      bus.rx_data = b;
      @(posedge clk);
      #1;
      last_rx_edge = cyc;
      bus.rx_rdy   = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   // Checks that the log holds a whole image written in address order.
   task automatic check_image(input string name, input logic val);
      int bad;
      bad = 0;
      check({name, "_count"}, log_addr.size(), NUM_PIXELS);
      foreach (log_addr[i]) begin
         if (log_addr[i] != i || log_data[i] !== val) bad++;
      end
      check({name, "_order"}, bad, 0);
   endtask

   int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int c3_bits[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
   int saved;
   int gap;

   initial begin
      rst           = 1'b1;
      bus.rx_rdy    = 1'b0;
      bus.rx_data   = '0;
      bus.snn_done  = 1'b0;
      bus.snn_digit = '0;
      bus.tx_rdy    = 1'b0;
      idle(3);
      rst = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_busy",    bus.busy,    0);
      check("rst_ovr",     bus.ovr,     0);
      check("rst_ram_we",  bus.ram_we,  0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      idle(1);

      // reset held two cycles in the middle of unpacking a byte
      send_byte(8'h3C);
      idle(3);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy",   bus.busy,   0);
      check("midrst_ovr",    bus.ovr,    0);
      check("midrst_ram_we", bus.ram_we, 0);
      idle(1);
      clear_log();
      send_byte(8'hA5);
      idle(12);
      check("a5_count", log_addr.size(), 8);
      foreach (a5_bits[i]) begin
         if (i < log_addr.size()) begin
            check("a5_addr", log_addr[i], i);
            check("a5_bit",  log_data[i], a5_bits[i]);
         end
      end

      // overrun: second byte three cycles after the first
      reset_dut();
      clear_log();
      send_byte(8'hC3);
      idle(2);
      send_byte(8'h81);
      idle(12);
      check("ovr_set",   bus.ovr,         1);
      check("ovr_count", log_addr.size(), 8);
      foreach (c3_bits[i]) begin
         if (i < log_addr.size()) begin
            check("ovr_addr", log_addr[i], i);
            check("ovr_bit",  log_data[i], c3_bits[i]);
         end
      end
      idle(20);
      check("ovr_sticky", bus.ovr, 1);

      // full image of 0xFF, 100 cycles apart
      reset_dut();
      clear_log();
      n_starts = 0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte(8'hFF);
         idle(99);
      end
      check_image("img1", 1'b1);
      check("img1_starts",     n_starts,        1);
      check("img1_start_time", last_start_edge, last_rx_edge + 9);

      // byte during COMPUTE is dropped
      saved = log_addr.size();
      send_byte(8'h55);
      idle(3);
      check("compute_ovr",    bus.ovr,         1);
      check("compute_nowr",   log_addr.size(), saved);

      // result path, UART ready
      n_txs         = 0;
      bus.tx_rdy    = 1'b1;
      bus.snn_digit = 4'd7;
      bus.snn_done  = 1'b1;
      idle(1);
      bus.snn_done  = 1'b0;
      @(negedge clk);
      check("res7_tx_start", bus.tx_start, 1);
      check("res7_tx_data",  bus.tx_data,  8'h37);
      idle(1);
      @(negedge clk);
      check("res7_load", bus.busy, 0);
      check("res7_once", n_txs,    1);
      idle(1);

      // second image of 0x00 with varying spacing
      clear_log();
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte(8'h00);
         idle($urandom_range(8, 19));
      end
      idle(20);
      check_image("img2", 1'b0);
      check("img2_starts", n_starts, 2);

      // UART backpressure with an out-of-range digit
      n_txs         = 0;
      bus.tx_rdy    = 1'b0;
      bus.snn_digit = 4'd12;
      bus.snn_done  = 1'b1;
      idle(1);
      bus.snn_done  = 1'b0;
      idle(50);
      check("bp_no_tx",   n_txs,       0);
      check("bp_tx_data", bus.tx_data, 8'h3F);
      check("bp_busy",    bus.busy,    1);
      bus.tx_rdy = 1'b1;
      idle(5);
      check("bp_one_tx", n_txs,    1);
      check("bp_load",   bus.busy, 0);
      clear_log();
      send_byte(8'h01);
      idle(10);
      check("bp_restart_count", log_addr.size(), 8);
      if (log_addr.size() > 0) check("bp_restart_addr", log_addr[0], 0);

      // randomized traffic, occasional reset (also coinciding with rx_rdy)
      reset_dut();
      gap = 0;
      repeat (6000) begin
         rst = ($urandom_range(0, 2999) == 0);
         if (gap == 0) begin
            bus.rx_rdy  = 1'b1;
            bus.rx_data = 8'($urandom);
            gap         = $urandom_range(6, 14);
         end else begin
            bus.rx_rdy = 1'b0;
            gap--;
         end
         bus.snn_done  = ($urandom_range(0, 15) == 0);
         bus.snn_digit = 4'($urandom_range(0, 15));
         bus.tx_rdy    = ($urandom_range(0, 3) != 0);
         idle(1);
      end
      rst          = 1'b0;
      bus.rx_rdy   = 1'b0;
      bus.snn_done = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
